// File: rtl/traffic_pkg.sv
// Shared types for the intersection scheduler: phase encoding, counter width,
// default phase durations and the lamp decode used by the registered output stage.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_GRN  = 3'd1,
        A_YEL  = 3'd2,
        RED_AB = 3'd3,
        B_GRN  = 3'd4,
        B_YEL  = 3'd5,
        RED_BA = 3'd6
    } phase_e;

    typedef logic [7:0] count_t;

    localparam int GREEN_T_DEF   = 60;
    localparam int YELLOW_T_DEF  = 5;
    localparam int ALLRED_T_DEF  = 2;
    localparam int MIN_GREEN_DEF = 10;

    typedef struct packed {
        logic a_red;
        logic a_yellow;
        logic a_green;
        logic b_red;
        logic b_yellow;
        logic b_green;
        logic walk_a;
        logic walk_b;
    } lamps_t;

    // Anything not explicitly a go/caution phase shows red both ways.
    function automatic lamps_t lamp_decode(input phase_e ph);
        lamps_t l;
        l       = '0;
        l.a_red = 1'b1;
        l.b_red = 1'b1;
        case (ph)
            A_GRN: begin l.a_red = 1'b0; l.a_green  = 1'b1; l.walk_b = 1'b1; end
            A_YEL: begin l.a_red = 1'b0; l.a_yellow = 1'b1; end
            B_GRN: begin l.b_red = 1'b0; l.b_green  = 1'b1; l.walk_a = 1'b1; end
            B_YEL: begin l.b_red = 1'b0; l.b_yellow = 1'b1; end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit loadable down-counter timing the current phase; last flags the final cycle.
module phase_timer
    import traffic_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  count_t load_val,
    input  logic   en,
    output count_t cnt,
    output logic   last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign last = (cnt == 8'd1);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-direction traffic light sequencer with pedestrian-triggered green shortening.
// All lamp and walk outputs are registered from the next-state decode.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_T   = GREEN_T_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int MIN_GREEN = MIN_GREEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       ped_req_a,
    input  logic       ped_req_b,
    output logic       a_red,
    output logic       a_yellow,
    output logic       a_green,
    output logic       b_red,
    output logic       b_yellow,
    output logic       b_green,
    output logic       walk_a,
    output logic       walk_b,
    output logic [7:0] remain,
    output logic [2:0] phase
);

    localparam count_t GREEN_LEN  = count_t'(GREEN_T);
    localparam count_t YELLOW_LEN = count_t'(YELLOW_T);
    localparam count_t ALLRED_LEN = count_t'(ALLRED_T);
    localparam count_t MIN_LEN    = count_t'(MIN_GREEN);

    phase_e state, nxt;
    logic   load, en, last, cut;
    count_t load_val, cnt;
    logic   pend_a, pend_b;
    lamps_t lamps_q;

    function automatic phase_e succ(input phase_e ph);
        case (ph)
            A_GRN:   return A_YEL;
            A_YEL:   return RED_AB;
            RED_AB:  return B_GRN;
            B_GRN:   return B_YEL;
            B_YEL:   return RED_BA;
            RED_BA:  return A_GRN;
            default: return IDLE;
        endcase
    endfunction

    function automatic count_t phase_len(input phase_e ph);
        case (ph)
            A_GRN, B_GRN:   return GREEN_LEN;
            A_YEL, B_YEL:   return YELLOW_LEN;
            RED_AB, RED_BA: return ALLRED_LEN;
            default:        return '0;
        endcase
    endfunction

    phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .cnt      (cnt),
        .last     (last)
    );

    // A pending request for road A shortens A's green so the B-green walk comes sooner.
    assign cut = (((state == A_GRN) && (pend_a || ped_req_a)) ||
                  ((state == B_GRN) && (pend_b || ped_req_b))) && (cnt > MIN_LEN);

    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        case (state)
            IDLE: begin
                if (!hold) begin
                    nxt      = A_GRN;
                    load     = 1'b1;
                    load_val = GREEN_LEN;
                end
            end
            A_GRN, A_YEL, RED_AB, B_GRN, B_YEL, RED_BA: begin
                if (!hold) begin
                    if (last) begin
                        nxt      = succ(state);
                        load     = 1'b1;
                        load_val = phase_len(succ(state));
                    end else if (cut) begin
                        load     = 1'b1;
                        load_val = MIN_LEN;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            default: begin
                nxt  = IDLE;
                load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lamps_q <= lamp_decode(IDLE);
        end else begin
            state   <= nxt;
            lamps_q <= lamp_decode(nxt);
        end
    end

    // Entering a green grants the walk, which discharges the matching request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else begin
            if ((nxt == B_GRN) && (state != B_GRN)) begin
                pend_a <= 1'b0;
            end else if (ped_req_a && (state != B_GRN)) begin
                pend_a <= 1'b1;
            end
            if ((nxt == A_GRN) && (state != A_GRN)) begin
                pend_b <= 1'b0;
            end else if (ped_req_b && (state != A_GRN)) begin
                pend_b <= 1'b1;
            end
        end
    end

    assign a_red    = lamps_q.a_red;
    assign a_yellow = lamps_q.a_yellow;
    assign a_green  = lamps_q.a_green;
    assign b_red    = lamps_q.b_red;
    assign b_yellow = lamps_q.b_yellow;
    assign b_green  = lamps_q.b_green;
    assign walk_a   = lamps_q.walk_a;
    assign walk_b   = lamps_q.walk_b;
    assign remain   = cnt;
    assign phase    = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: a cycle model predicts every output,
// plus directed checks on the timing landmarks of the sequence.
module tb_intersection_scheduler;

    localparam int GREEN = 60;
    localparam int YEL   = 5;
    localparam int ARED  = 2;
    localparam int MING  = 10;

    logic       clk;
    logic       rst, hold, ped_req_a, ped_req_b;
    logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk_a, walk_b;
    logic [7:0] remain;
    logic [2:0] phase;

    typedef struct {
        int         ph;
        int         rem;
        logic [7:0] lamps;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ph, m_cnt;
    bit   m_pa, m_pb;

    intersection_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .ped_req_a (ped_req_a),
        .ped_req_b (ped_req_b),
        .a_red     (a_red),
        .a_yellow  (a_yellow),
        .a_green   (a_green),
        .b_red     (b_red),
        .b_yellow  (b_yellow),
        .b_green   (b_green),
        .walk_a    (walk_a),
        .walk_b    (walk_b),
        .remain    (remain),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input int ph);
        case (ph)
            1, 4:    return GREEN;
            2, 5:    return YEL;
            3, 6:    return ARED;
            default: return 0;
        endcase
    endfunction

    // {a_red,a_yellow,a_green,b_red,b_yellow,b_green,walk_a,walk_b}
    function automatic logic [7:0] lamps_of(input int ph);
        case (ph)
            1:       return 8'b0011_0001;
            2:       return 8'b0101_0000;
            4:       return 8'b1000_0110;
            5:       return 8'b1000_1000;
            default: return 8'b1001_0000;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit h, input bit ra, input bit rb);
        int nph, ncnt;
        if (r) begin
            m_ph = 0; m_cnt = 0; m_pa = 0; m_pb = 0;
            return;
        end
        nph  = m_ph;
        ncnt = m_cnt;
        if (!h) begin
            if (m_ph == 0) begin
                nph = 1; ncnt = GREEN;
            end else if (m_cnt == 1) begin
                nph  = (m_ph == 6) ? 1 : m_ph + 1;
                ncnt = len_of(nph);
            end else if (m_ph == 1 && (m_pa || ra) && m_cnt > MING) begin
                ncnt = MING;
            end else if (m_ph == 4 && (m_pb || rb) && m_cnt > MING) begin
                ncnt = MING;
            end else begin
                ncnt = m_cnt - 1;
            end
        end
        if (nph == 4 && m_ph != 4) m_pa = 0;
        else if (ra && m_ph != 4)  m_pa = 1;
        if (nph == 1 && m_ph != 1) m_pb = 0;
        else if (rb && m_ph != 1)  m_pb = 1;
        m_ph  = nph;
        m_cnt = ncnt;
    endtask

    task automatic step(input bit r, input bit h, input bit ra, input bit rb);
        exp_t e;
        rst = r; hold = h; ped_req_a = ra; ped_req_b = rb;
        model_step(r, h, ra, rb);
        e.ph = m_ph; e.rem = m_cnt; e.lamps = lamps_of(m_ph);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_eq("sb_phase", int'(phase), e.ph);
        check_eq("sb_remain", int'(remain), e.rem);
        check_eq("sb_lamps", int'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk_a, walk_b}),
                 int'(e.lamps));
        check_eq("no_dual_green", int'(a_green & b_green), 0);
    endtask

    task automatic run_to(input int ph, input int rem, output int n);
        n = 0;
        while (!(int'(phase) == ph && int'(remain) == rem) && n < 400) begin
            step(0, 0, 0, 0);
            n++;
        end
        check_eq("reach_phase", int'(phase), ph);
        check_eq("reach_remain", int'(remain), rem);
    endtask

    initial begin
        int n;
        rst = 1'b1; hold = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
        m_ph = 0; m_cnt = 0; m_pa = 0; m_pb = 0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("rst_phase", int'(phase), 0);
        check_eq("rst_remain", int'(remain), 0);
        check_eq("rst_reds", int'({a_red, b_red}), 3);

        step(0, 0, 0, 0);
        check_eq("first_agrn_phase", int'(phase), 1);
        check_eq("first_agrn_remain", int'(remain), 60);

        for (int i = 0; i < 133; i++) step(0, 0, 0, 0);
        check_eq("cycle_end_phase", int'(phase), 6);
        check_eq("cycle_end_remain", int'(remain), 1);
        step(0, 0, 0, 0);
        check_eq("wrap_phase", int'(phase), 1);
        check_eq("wrap_remain", int'(remain), 60);

        // Pedestrian A at remain=40 cuts the green to MIN_GREEN.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check_eq("pre_cut_remain", int'(remain), 40);
        step(0, 0, 1, 0);
        check_eq("cut_remain", int'(remain), 10);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check_eq("cut_then_yellow", int'(phase), 2);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        check_eq("bgrn_phase", int'(phase), 4);
        check_eq("bgrn_walk_a", int'(walk_a), 1);

        // Request during B_GRN is dropped; next A_GRN runs full length.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_eq("drop_remain", int'(remain), 49);
        run_to(1, 60, n);
        run_to(1, 7, n);
        check_eq("full_green_steps", n, 53);
        step(0, 0, 1, 0);
        check_eq("no_cut_low", int'(remain), 6);

        // Hold in B_GRN with a B request latched meanwhile.
        run_to(4, 30, n);
        for (int i = 0; i < 20; i++) step(0, 1, 0, (i == 5));
        check_eq("hold_remain", int'(remain), 30);
        check_eq("hold_phase", int'(phase), 4);
        check_eq("hold_b_green", int'(b_green), 1);
        step(0, 0, 0, 0);
        check_eq("release_cut", int'(remain), 10);

        // Request on the final RED_BA cycle: transition first, cut next.
        run_to(6, 1, n);
        step(0, 0, 1, 0);
        check_eq("coinc_phase", int'(phase), 1);
        check_eq("coinc_remain", int'(remain), 60);
        step(0, 0, 0, 0);
        check_eq("coinc_cut", int'(remain), 10);

        // Reset under hold mid A_YEL with a pending request.
        run_to(2, 3, n);
        step(0, 1, 1, 0);
        step(1, 1, 0, 0);
        check_eq("midrst_phase", int'(phase), 0);
        check_eq("midrst_remain", int'(remain), 0);
        check_eq("midrst_reds", int'({a_red, b_red, a_green, b_green, a_yellow, b_yellow}), 6'b110000);
        step(0, 0, 0, 0);
        check_eq("post_rst_agrn", int'(remain), 60);
        step(0, 0, 0, 0);
        check_eq("pend_cleared", int'(remain), 59);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
